// File: rtl/apb_pkg.sv
// Shared definitions for the APB master bridge.
//   apb_state_e  : bridge FSM states (IDLE -> SETUP -> ACCESS -> RESP)
//   PROT_*       : bit positions inside pprot / cmd_prot
//   DEF_*        : default bus widths
//   timer_width  : width of the wait-state timer for a given TIMEOUT
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam int PROT_PRIV   = 0;
  localparam int PROT_NONSEC = 1;
  localparam int PROT_INSTR  = 2;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // clog2(TIMEOUT+1), never narrower than one bit so TIMEOUT=0 still builds.
  function automatic int timer_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state timer for the APB ACCESS phase.
// Ports:
//   pclk, preset : clock, async active-low reset
//   clear        : zero the count (asserted in SETUP)
//   enable       : count one ACCESS cycle that lacked pready
//   expired      : count has reached TIMEOUT-1, so the current ACCESS
//                  cycle is the last one allowed; always 0 when TIMEOUT=0
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic pclk,
  input  logic preset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = timer_width(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != SAT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (TIMEOUT != 0) && (cnt_q == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// Bridges a valid/ready command stream onto single APB4 transfers and
// returns read data / error status on a valid/ready response stream.
// Ports:
//   pclk, preset                      : clock, async active-low reset
//   cmd_valid/ready/write/addr/wdata/strb/prot : command channel
//   rsp_valid/ready/rdata/err/timeout : response channel
//   psel/penable/paddr/pwrite/pprot/pwdata/pstrb/prdata/pready/pslverr : APB
//   dbg_state_o                       : current FSM state
// Handshakes: a beat transfers on a rising edge where valid & ready are both
// 1. The bridge never withdraws rsp_valid or changes rsp_* before that edge.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  input  logic [2:0]          cmd_prot,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                psel,
  output logic                penable,
  output logic [ADDR_W-1:0]   paddr,
  output logic                pwrite,
  output logic [2:0]          pprot,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr,
  output logic [1:0]          dbg_state_o
);

  localparam int STRB_W = DATA_W / 8;

  apb_state_e state_q, state_d;

  logic [ADDR_W-1:0] paddr_q,  paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [2:0]        pprot_q,  pprot_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [STRB_W-1:0] pstrb_q,  pstrb_d;
  logic [DATA_W-1:0] rdata_q,  rdata_d;
  logic              err_q,    err_d;
  logic              tmo_q,    tmo_d;

  logic timer_clear, timer_en, timer_expired;

  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .pclk    (pclk),
    .preset  (preset),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pprot_d     = pprot_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    tmo_d       = tmo_q;
    timer_clear = 1'b0;
    timer_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d              = cmd_addr;
          pwrite_d             = cmd_write;
          pwdata_d             = cmd_wdata;
          // Reads present no active byte lanes.
          pstrb_d              = cmd_write ? cmd_strb : '0;
          pprot_d[PROT_PRIV]   = cmd_prot[PROT_PRIV];
          pprot_d[PROT_NONSEC] = cmd_prot[PROT_NONSEC];
          pprot_d[PROT_INSTR]  = cmd_prot[PROT_INSTR];
          state_d              = SETUP;
        end
      end
      SETUP: begin
        timer_clear = 1'b1;
        state_d     = ACCESS;
      end
      ACCESS: begin
        // pready has priority over a timeout firing in the same cycle.
        if (pready) begin
          rdata_d = pwrite_q ? '0 : prdata;
          err_d   = pslverr;
          tmo_d   = 1'b0;
          state_d = RESP;
        end else if (timer_expired) begin
          rdata_d = '0;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = RESP;
        end else begin
          timer_en = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pprot_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pprot_q  <= pprot_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

  // Bus controls decode straight from the state so reset clears them at once.
  assign cmd_ready   = preset && (state_q == IDLE);
  assign psel        = (state_q == SETUP) || (state_q == ACCESS);
  assign penable     = (state_q == ACCESS);
  assign rsp_valid   = (state_q == RESP);
  assign paddr       = paddr_q;
  assign pwrite      = pwrite_q;
  assign pprot       = pprot_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = tmo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge (TIMEOUT=4): directed command vectors, an APB
// completer model, and a response scoreboard fed at command acceptance.
module tb_apb_master_bridge;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_strb = '0;
  logic [2:0]  cmd_prot = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        psel;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [2:0]  pprot;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;
  logic [1:0]  dbg_state;

  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .pclk        (pclk),
    .preset      (preset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_strb    (cmd_strb),
    .cmd_prot    (cmd_prot),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .psel        (psel),
    .penable     (penable),
    .paddr       (paddr),
    .pwrite      (pwrite),
    .pprot       (pprot),
    .pwdata      (pwdata),
    .pstrb       (pstrb),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 pclk = ~pclk;

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  // {rdata[31:0], err, timeout, latency[7:0], access_cycles[7:0]}
  logic [49:0] exp_q[$];

  time         accept_time = 0;
  time         rel_time = 0;
  logic        cur_wr = 1'b0;
  logic [31:0] cur_addr = '0;
  logic [31:0] cur_wdata = '0;
  logic [3:0]  cur_strb = '0;
  logic [2:0]  cur_prot = '0;

  // completer model configuration
  int          s_wait = 0;
  logic        s_never = 1'b0;
  logic        s_err = 1'b0;
  logic        s_setup_pulse = 1'b0;
  logic [31:0] s_rdata = '0;
  int          acc_cnt = 0;
  int          acc_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- APB completer model ----------------
  // Drives pready/pslverr/prdata just after each rising edge for the cycle
  // that follows, based on the phase the bridge is now in.
  always @(posedge pclk) begin
    #1;
    if (psel && penable) begin
      pready    = !s_never && (acc_cnt == s_wait);
      pslverr   = pready ? s_err : 1'b0;
      prdata    = s_rdata;
      acc_cnt   = acc_cnt + 1;
      acc_total = acc_cnt;
    end else if (psel) begin
      pready  = s_setup_pulse;
      pslverr = s_setup_pulse;
      prdata  = s_rdata;
      acc_cnt = 0;
    end else begin
      pready  = 1'b0;
      pslverr = 1'b0;
      acc_cnt = 0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic        prev_valid = 1'b0;
  logic [31:0] held_rdata = '0;
  logic        held_err = 1'b0;
  logic        held_to = 1'b0;

  always @(negedge pclk) begin
    logic [49:0] e;
    int lat;
    if (!preset) begin
      prev_valid = 1'b0;
    end else begin
      if (psel || rsp_valid) chk("cmd_ready_busy", cmd_ready, 0);
      if (psel) begin
        chk("paddr", paddr, cur_addr);
        chk("pwrite", pwrite, cur_wr);
        chk("pprot", pprot, cur_prot);
        chk("pstrb", pstrb, cur_wr ? cur_strb : 4'h0);
        if (cur_wr) chk("pwdata", pwdata, cur_wdata);
      end
      if (rsp_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          e   = exp_q[0];
          lat = int'(($time - accept_time) / 10) + 1;
          chk("latency", lat, e[15:8]);
          chk("access_cycles", acc_total, e[7:0]);
        end
        held_rdata = rsp_rdata;
        held_err   = rsp_err;
        held_to    = rsp_timeout;
      end else if (rsp_valid) begin
        chk("hold_rdata", rsp_rdata, held_rdata);
        chk("hold_err", rsp_err, held_err);
        chk("hold_timeout", rsp_timeout, held_to);
      end
      if (rsp_valid && rsp_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e[49:18]);
        chk("rsp_err", rsp_err, e[17]);
        chk("rsp_timeout", rsp_timeout, e[16]);
      end
      prev_valid = rsp_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [2:0] prot, input logic push,
                        input logic [31:0] e_rdata, input logic e_err, input logic e_to,
                        input int e_lat, input int e_acc);
    int   guard;
    logic done;
    guard = 0;
    done  = 1'b0;
    @(posedge pclk); #1;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_strb  = strb;
    cmd_prot  = prot;
    while (!done && guard < 50) begin
      @(negedge pclk);
      if (cmd_ready) done = 1'b1;
      else guard++;
    end
    if (!done) begin
      chk("cmd_accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge pclk); #1;
    accept_time = $time;
    cmd_valid   = 1'b0;
    cur_wr      = wr;
    cur_addr    = addr;
    cur_wdata   = wdata;
    cur_strb    = strb;
    cur_prot    = prot;
    if (push) exp_q.push_back({e_rdata, e_err, e_to, 8'(e_lat), 8'(e_acc)});
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    do begin
      @(negedge pclk);
      guard++;
    end while (!(exp_q.size() == 0 && !rsp_valid && !psel) && guard < 100);
    if (guard >= 100) chk("drain_timeout", 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int g;

    // reset with a command already pending
    cmd_valid = 1'b1;
    #2 preset = 1'b0;
    #20;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_pstrb", pstrb, 0);
    chk("rst_pprot", pprot, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    cmd_valid = 1'b0;
    @(posedge pclk); #2;
    preset = 1'b1;

    // 1: write, zero wait states; prdata is noise that must not leak back
    s_wait = 0; s_never = 1'b0; s_err = 1'b0; s_rdata = 32'h5A5A_5A5A;
    do_cmd(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 3'b010, 1'b1, 32'h0, 1'b0, 1'b0, 3, 1);
    wait_idle();

    // 2: read with three wait states
    s_wait = 3; s_rdata = 32'h1234_5678;
    do_cmd(1'b0, 32'h04, 32'hFFFF_0000, 4'hF, 3'b000, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 6, 4);
    wait_idle();

    // 3: read completing with pslverr
    s_wait = 0; s_err = 1'b1; s_rdata = 32'hCAFE_F00D;
    do_cmd(1'b0, 32'h08, 32'h0, 4'h0, 3'b001, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b0, 3, 1);
    wait_idle();

    // 4: pready/pslverr pulsed during SETUP only; real completion one wait later
    s_wait = 1; s_err = 1'b0; s_setup_pulse = 1'b1; s_rdata = 32'h0BAD_C0DE;
    do_cmd(1'b0, 32'h0C, 32'h0, 4'hF, 3'b011, 1'b1, 32'h0BAD_C0DE, 1'b0, 1'b0, 4, 2);
    wait_idle();
    s_setup_pulse = 1'b0;

    // 5: completer never ready -> timeout after 4 ACCESS cycles
    s_never = 1'b1; s_rdata = 32'hFFFF_FFFF;
    do_cmd(1'b0, 32'h20, 32'h0, 4'h0, 3'b101, 1'b1, 32'h0, 1'b1, 1'b1, 6, 4);
    wait_idle();
    s_never = 1'b0;

    // 6: response back-pressure with the next command waiting
    s_wait = 0; s_rdata = 32'h9999_9999;
    rsp_ready = 1'b0;
    do_cmd(1'b1, 32'h30, 32'h1122_3344, 4'h5, 3'b001, 1'b1, 32'h0, 1'b0, 1'b0, 3, 1);
    fork
      do_cmd(1'b0, 32'h34, 32'h0, 4'hF, 3'b100, 1'b1, 32'hA5A5_5A5A, 1'b0, 1'b0, 5, 3);
      begin
        g = 0;
        while (!rsp_valid && g < 50) begin
          @(negedge pclk);
          g++;
        end
        if (g >= 50) chk("bp_rsp_timeout", 0, 1);
        s_wait  = 2;
        s_rdata = 32'hA5A5_5A5A;
        repeat (5) @(negedge pclk);
        @(posedge pclk); #1;
        rsp_ready = 1'b1;
        rel_time  = $time;
      end
    join
    // handshake edge, one IDLE cycle, then accept edge
    chk("bp_accept_gap", accept_time - rel_time, 20);
    wait_idle();

    // 7: reset pulled in ACCESS; dropped command, then a clean transfer
    s_never = 1'b1;
    do_cmd(1'b0, 32'h40, 32'h0, 4'h0, 3'b000, 1'b0, 32'h0, 1'b0, 1'b0, 0, 0);
    g = 0;
    while (!(psel && penable) && g < 20) begin
      @(negedge pclk);
      g++;
    end
    if (g >= 20) chk("reach_access_timeout", 0, 1);
    @(posedge pclk); #2;
    preset = 1'b0;
    #1;
    chk("midrst_psel", psel, 0);
    chk("midrst_penable", penable, 0);
    chk("midrst_cmd_ready", cmd_ready, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_paddr", paddr, 0);
    repeat (2) @(negedge pclk);
    @(posedge pclk); #2;
    preset  = 1'b1;
    s_never = 1'b0;
    repeat (3) begin
      @(negedge pclk);
      chk("no_rsp_after_reset", rsp_valid, 0);
    end
    s_wait = 1; s_rdata = 32'h7777_7777;
    do_cmd(1'b1, 32'h44, 32'h55AA_55AA, 4'h3, 3'b110, 1'b1, 32'h0, 1'b0, 1'b0, 4, 2);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global time limit
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "time limit");
  end

endmodule
